// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer.
package acq_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } acq_state_e;

    // Width of the completed-acquisition counter.
    localparam int ACQ_COUNT_WIDTH = 16;

endpackage

// File: rtl/acq_sequencer_if.sv
// Sample stream in and BRAM write port out, bundled for the sequencer.
interface acq_sequencer_if #(
    parameter int BRAM_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic [BRAM_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_wdata;
    logic                  bram_we;

    // Producer of samples / consumer of BRAM writes.
    modport master (
        output s_data, s_valid,
        input  bram_addr, bram_wdata, bram_we
    );

    // The sequencer side.
    modport slave (
        input  s_data, s_valid,
        output bram_addr, bram_wdata, bram_we
    );
endinterface

// File: rtl/acq_decimator.sv
// Decimation counter: strobes on the first valid sample after clear and
// then on every (dec+1)-th valid sample.
module acq_decimator
    import acq_pkg::*;
#(
    parameter int DEC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sample,
    input  logic [DEC_WIDTH-1:0] dec,
    output logic                 wr_stb
);

    logic [DEC_WIDTH-1:0] cnt_q;
    logic [DEC_WIDTH-1:0] cnt_d;

    // Next counter value: cleared outside capture, wraps from dec to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {DEC_WIDTH{1'b0}};
        end else if (sample) begin
            if (cnt_q == dec) begin
                cnt_d = {DEC_WIDTH{1'b0}};
            end else begin
                cnt_d = cnt_q + DEC_WIDTH'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {DEC_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wr_stb = sample && (cnt_q == {DEC_WIDTH{1'b0}});

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms on start, waits for trig/sync, writes
// decimated samples to BRAM at addresses 0..last_addr, then reports done.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int BRAM_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int DEC_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       continuous,
    input  logic                       trig_en,
    input  logic                       trig,
    input  logic                       sync,
    input  logic [BRAM_WIDTH-1:0]      last_addr,
    input  logic [DEC_WIDTH-1:0]       dec,
    acq_sequencer_if.slave             bus,
    output logic                       busy,
    output logic                       done,
    output logic [ACQ_COUNT_WIDTH-1:0] acq_count
);

    acq_state_e                 state_q, state_d;
    logic [BRAM_WIDTH-1:0]      last_addr_q, last_addr_d;
    logic [DEC_WIDTH-1:0]       dec_q, dec_d;
    logic                       trig_en_q, trig_en_d;
    logic [BRAM_WIDTH-1:0]      addr_q, addr_d;
    logic                       we_q, we_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [BRAM_WIDTH-1:0]      waddr_q, waddr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [ACQ_COUNT_WIDTH-1:0] count_q, count_d;
    logic                       wr_stb_s;

    acq_decimator #(.DEC_WIDTH(DEC_WIDTH)) u_dec (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_CAPTURE),
        .sample ((state_q == ST_CAPTURE) && bus.s_valid),
        .dec    (dec_q),
        .wr_stb (wr_stb_s)
    );

    // Next-state, parameter latching, address counter and output values.
    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        dec_d       = dec_q;
        trig_en_d   = trig_en_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        done_d      = 1'b0;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                // Abort beats a simultaneous start.
                if (start && !abort) begin
                    state_d     = ST_ARMED;
                    last_addr_d = last_addr;
                    dec_d       = dec;
                    trig_en_d   = trig_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                addr_d = {BRAM_WIDTH{1'b0}};
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (trig_en_q ? trig : sync) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wr_stb_s) begin
                    we_d    = 1'b1;
                    wdata_d = bus.s_data;
                    waddr_d = addr_q;
                    // The final write closes the capture in the same edge.
                    if (addr_q == last_addr_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        count_d = count_q + ACQ_COUNT_WIDTH'(1'b1);
                    end else begin
                        addr_d = addr_q + BRAM_WIDTH'(1'b1);
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (continuous) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, latched parameters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_addr_q <= {BRAM_WIDTH{1'b0}};
            dec_q       <= {DEC_WIDTH{1'b0}};
            trig_en_q   <= 1'b0;
            addr_q      <= {BRAM_WIDTH{1'b0}};
            we_q        <= 1'b0;
            wdata_q     <= {DATA_WIDTH{1'b0}};
            waddr_q     <= {BRAM_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= {ACQ_COUNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            dec_q       <= dec_d;
            trig_en_q   <= trig_en_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign bus.bram_we    = we_q;
    assign bus.bram_wdata = wdata_q;
    assign bus.bram_addr  = waddr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign acq_count      = count_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer.
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic        trig_en = 1'b0;
    logic        trig = 1'b0;
    logic        sync = 1'b0;
    logic [12:0] last_addr = 13'd0;
    logic [15:0] dec = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] acq_count;

    int errors = 0;
    int checks = 0;

    int wr_addr[$];
    int wr_data[$];
    int done_cnt = 0;
    bit busy_track = 1'b0;
    bit busy_dropped = 1'b0;

    acq_sequencer_if #(.BRAM_WIDTH(13), .DATA_WIDTH(32)) bus ();

    acq_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .trig_en    (trig_en),
        .trig       (trig),
        .sync       (sync),
        .last_addr  (last_addr),
        .dec        (dec),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .acq_count  (acq_count)
    );

    always #5 clk = ~clk;

    // Record writes, done pulses and busy drops, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.bram_we === 1'b1) begin
            wr_addr.push_back(int'(bus.bram_addr));
            wr_data.push_back(int'(bus.bram_wdata));
        end
        if (done === 1'b1) done_cnt++;
        if (busy_track && busy !== 1'b1) busy_dropped = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic run_samples(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(first + i);
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic arm(input int la, input int d, input bit te, input bit cont);
        last_addr  = 13'(la);
        dec        = 16'(d);
        trig_en    = te;
        continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus.bram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.bram_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (acq_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", acq_count); end
        checks++; if (bus.bram_addr !== 13'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.bram_addr); end
        checks++; if (bus.bram_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%0d exp=0", bus.bram_wdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_shot();
        clear_log();
        arm(7, 0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run_samples(100, 10);
        tick();
        checks++; if (wr_addr.size() != 8) begin errors++; $display("FAIL single_nwr got=%0d exp=8", wr_addr.size()); end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != 100 + i) begin
                errors++; $display("FAIL single_wr%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i, 100 + i);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
        checks++; if (acq_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", acq_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_decimation();
        int exp_d[4] = '{0, 3, 6, 9};
        clear_log();
        arm(3, 2, 1'b0, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run_samples(0, 21);
        tick();
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL dec_nwr got=%0d exp=4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != exp_d[i]) begin
                errors++; $display("FAIL dec_wr%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i, exp_d[i]);
            end
        end
        checks++; if (acq_count !== 16'd2) begin errors++; $display("FAIL dec_count got=%0d exp=2", acq_count); end
    endtask

    task automatic test_trigger();
        clear_log();
        arm(3, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(200 + i);
            sync = (i % 2 == 0);
            tick();
        end
        sync = 1'b0;
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL trig_armed_nwr got=%0d exp=0", wr_addr.size()); end
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd300;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        run_samples(301, 6);
        tick();
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL trig_nwr got=%0d exp=4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != 301 + i) begin
                errors++; $display("FAIL trig_wr%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i, 301 + i);
            end
        end
        checks++; if (acq_count !== 16'd3) begin errors++; $display("FAIL trig_count got=%0d exp=3", acq_count); end
    endtask

    task automatic test_continuous();
        clear_log();
        arm(3, 0, 1'b1, 1'b1);
        busy_dropped = 1'b0;
        busy_track = 1'b1;
        for (int k = 0; k < 3; k++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            run_samples(400 + 10 * k, 6);
        end
        busy_track = 1'b0;
        checks++; if (busy_dropped) begin errors++; $display("FAIL cont_busy got=dropped exp=held"); end
        checks++; if (done_cnt != 3) begin errors++; $display("FAIL cont_done got=%0d exp=3", done_cnt); end
        checks++; if (acq_count !== 16'd6) begin errors++; $display("FAIL cont_count got=%0d exp=6", acq_count); end
        checks++; if (wr_addr.size() != 12) begin errors++; $display("FAIL cont_nwr got=%0d exp=12", wr_addr.size()); end
        for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] != i % 4 || wr_data[i] != 400 + 10 * (i / 4) + i % 4) begin
                errors++; $display("FAIL cont_wr%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i % 4, 400 + 10 * (i / 4) + i % 4);
            end
        end
        continuous = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        clear_log();
        arm(7, 0, 1'b0, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run_samples(700, 4);
        checks++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 13'd3) begin
            errors++; $display("FAIL abort_pre got=%b/%0d exp=1/3", bus.bram_we, bus.bram_addr);
        end
        abort = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd704;
        tick();
        abort = 1'b0;
        checks++; if (bus.bram_we !== 1'b0) begin errors++; $display("FAIL abort_we got=%b exp=0", bus.bram_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        run_samples(705, 4);
        tick();
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL abort_nwr got=%0d exp=4", wr_addr.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        checks++; if (acq_count !== 16'd6) begin errors++; $display("FAIL abort_count got=%0d exp=6", acq_count); end
        clear_log();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got=%b exp=0", busy); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run_samples(800, 4);
        tick();
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL abort_start_nwr got=%0d exp=0", wr_addr.size()); end
    endtask

    task automatic test_reset_mid();
        arm(7, 0, 1'b0, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run_samples(500, 3);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd503;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.bram_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b exp=0", bus.bram_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++; if (acq_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", acq_count); end
        checks++; if (bus.bram_addr !== 13'd0) begin errors++; $display("FAIL rstmid_addr got=%0d exp=0", bus.bram_addr); end
        checks++; if (bus.bram_wdata !== 32'd0) begin errors++; $display("FAIL rstmid_wdata got=%0d exp=0", bus.bram_wdata); end
        bus.s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        clear_log();
        arm(3, 0, 1'b0, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        run_samples(600, 6);
        tick();
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL rstmid_nwr got=%0d exp=4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != 600 + i) begin
                errors++; $display("FAIL rstmid_wr%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i, 600 + i);
            end
        end
        checks++; if (acq_count !== 16'd1) begin errors++; $display("FAIL rstmid_after_count got=%0d exp=1", acq_count); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 32'd0;
        test_reset();
        test_single_shot();
        test_decimation();
        test_trigger();
        test_continuous();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter BRAM_WIDTH, default 13, BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, sample and BRAM word width.
REQ-003 Parameter DEC_WIDTH, default 16, decimation counter width.
REQ-004 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to arm one acquisition.
REQ-007 abort  in  1  one-cycle request to return to IDLE.
REQ-008 continuous  in  1  level; re-arms automatically after each acquisition.
REQ-009 trig_en  in  1  level; 1 = wait for trig, 0 = wait for sync.
REQ-010 trig  in  1  external trigger pulse.
REQ-011 sync  in  1  upstream frame-start pulse.
REQ-012 last_addr  in  BRAM_WIDTH  final write address (capture length minus 1).
REQ-013 dec  in  DEC_WIDTH  decimation: store 1 of every dec+1 valid samples.
REQ-014 s_data / s_valid  in  DATA_WIDTH / 1  sample stream; no back-pressure.
REQ-015 bram_addr / bram_wdata / bram_we  out  BRAM_WIDTH / DATA_WIDTH / 1  BRAM write port.
REQ-016 busy / done / acq_count  out  1 / 1 / 16  status.

Function
REQ-017 States: IDLE, ARMED, CAPTURE, DONE.
REQ-018 IDLE -> ARMED on start; last_addr, dec and trig_en are latched at that edge and held constant for the acquisition.
REQ-019 ARMED -> CAPTURE on the first trig (latched trig_en=1) or sync (latched trig_en=0); a sync or trig arriving in the same cycle as start is ignored.
REQ-020 In CAPTURE, each s_valid advances the decimation counter; a write occurs when the counter equals 0, and the counter wraps from dec to 0.
REQ-021 The first s_valid in CAPTURE is always written; dec=0 writes every valid sample.
REQ-022 Write timing: registered outputs; bram_we=1, bram_wdata=s_data and bram_addr=current address one cycle after the qualifying s_valid; address starts at 0.
REQ-023 The write to last_addr ends capture: CAPTURE -> DONE in the same cycle that write is issued; last_addr=0 gives a single-word capture.
REQ-024 DONE lasts 1 cycle, during which acq_count increments (wraps at 0xFFFF) and done pulses high for 1 cycle.
REQ-025 DONE -> ARMED if continuous=1, otherwise DONE -> IDLE; the parameters latched at start are retained for re-arming.
REQ-026 busy=1 in ARMED, CAPTURE and DONE.
REQ-027 abort in any state -> IDLE next cycle: no further writes, done is not asserted, acq_count is unchanged; abort wins over a simultaneous start.
REQ-028 start while busy is ignored.
REQ-029 bram_addr never exceeds last_addr, and no write is issued outside CAPTURE.

Reset
REQ-030 On rst, all outputs are 0 immediately: bram_we, busy, done, acq_count, bram_addr, bram_wdata.
REQ-031 On rst, the state is IDLE and all latched parameters are 0; rst is synchronously deasserted upstream.
REQ-032 rst mid-capture discards the acquisition, and BRAM contents are undefined.

Structure
REQ-033 Package acq_pkg holds the state enum and the ACQ_COUNT_WIDTH=16 constant.
REQ-034 Sub-module acq_decimator (counter plus write strobe) is instantiated once; the FSM and address counter stay in the top level.

Verification
REQ-035 Single shot: last_addr=7, dec=0, trig_en=0, continuous=0, s_valid constant; start, then sync -> 8 writes at addr 0..7 with consecutive data, done=1 for 1 cycle, acq_count=1, then IDLE.
REQ-036 Decimation: dec=2, last_addr=3, samples 0..20 -> words 0, 3, 6, 9 written at addr 0..3.
REQ-037 Trigger: trig_en=1; sync pulses while ARMED -> no writes; trig -> capture begins, and the first written word is the first valid sample after trig.
REQ-038 Continuous: continuous=1, last_addr=3 over 3 triggers -> 3 done pulses, acq_count=3, busy held high throughout.
REQ-039 Abort: abort at write 4 of 8 -> bram_we=0 next cycle, no done, acq_count unchanged; abort and start in the same cycle -> stays IDLE.
REQ-040 Reset: rst asserted mid-capture -> all outputs 0 without waiting for a clk edge; start after release -> normal capture from addr 0.
